aud_rmm_ctrl: RTL and testbench
===============================

Name: aud_rmm_ctrl

Overview:
Parametrised second-generation AUD remote-memory-access master. It serialises a read or write command over the 4-bit AUD bus: sync, command nibble, address nibbles, then data nibbles (write) or captured nibbles (read). The bus turnaround cycle count and the ready-poll timeout are configurable, and it returns a coded error. It sits between the host-side register/bus bridge and the AUD pad ring; the tristate buffer is instantiated at top level.

Parameters:
ADDR_NIBBLES, 8, number of address nibbles sent LSB-first (1..8)
TURN_CYCLES, 1, cycles with the bus released before ready polling starts (1..15)
TIMEOUT_CYCLES, 1024, maximum poll cycles in WAIT before a timeout error (>=2)
TO_W, 11, timeout counter width, must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
clk_i  in  1  sole clock, all logic on rising edge
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  request strobe, accepted only in IDLE
we_i  in  1  1=write, 0=read; sampled with start_i
addr_i  in  32  target address; bits above 4*ADDR_NIBBLES are ignored
data_i  in  32  write data, sampled with start_i
size_i  in  2  transfer size: 2^size_i nibbles (1,2,4,8)
data_o  out  32  read data, zero-extended above the transferred nibbles
busy_o  out  1  high from accept until return to IDLE
done_o  out  1  one-cycle completion pulse, with or without error
err_code_o  out  2  00 ok, 01 target status error, 10 timeout; held until next accept
aud_data_i  in  4  AUD bus input from pad
aud_data_o  out  4  AUD bus output to pad
aud_data_oe_o  out  1  pad output enable
aud_nsync_o  out  1  AUD sync, active low

Behaviour:
- Reset values: data_o=0, busy_o=0, done_o=0, err_code_o=00, aud_data_o=0, aud_data_oe_o=0, aud_nsync_o=1, state=IDLE.
- Reset asserted mid-transfer: outputs take their reset values immediately and asynchronously; no done_o pulse.
- States: IDLE, SYNC, CMD, ADDR, WDATA, TURN, WAIT, RDATA, DONE.
- IDLE: on start_i=1, latch we, addr, data and size; clear err_code_o; set busy_o=1; go to SYNC. start_i is ignored when not in IDLE.
- SYNC (1 cycle): nsync=0, oe=1, aud_data_o=0000.
- CMD (1 cycle): aud_data_o={1, we, size}. Write = 11ss, read = 10ss.
- ADDR (ADDR_NIBBLES cycles): nibble k = addr[4k+3:4k], k ascending.
- WDATA (write only, 2^size cycles): nibble k = data[4k+3:4k].
- After ADDR (read) or WDATA (write), go to TURN.
- TURN: oe=0, nsync stays 0, for TURN_CYCLES cycles; aud_data_i is ignored.
- WAIT: poll aud_data_i every cycle.
  - If aud_data_i[3:1]!=0: err=01, go to DONE. Error takes priority over ready in the same cycle.
  - Else if aud_data_i[0]=1: a write goes to DONE; a read sets nsync=1 and goes to RDATA.
  - If the poll count reaches TIMEOUT_CYCLES with no event: err=10, go to DONE.
- RDATA (2^size cycles): capture nibble k from aud_data_i on the k-th rising edge after ready was sampled. On the last capture, write data_o with the upper unused nibbles = 0 and go to DONE.
- DONE (1 cycle): done_o=1, nsync=1, oe=0, busy_o=0 from the next cycle; return to IDLE. start_i is first accepted in the IDLE cycle after DONE.
- data_o is unchanged on writes and on errored reads.
- Write latency from accept to done_o: 2 + ADDR_NIBBLES + 2^size + TURN_CYCLES + W + 1 cycles, where W is the number of poll cycles including the ready cycle.

Test Plan:
- Write, size=3, addr=0x1234_5678, data=0xCAFE_BABE, ready on the 3rd poll: bus shows 0,F,8,7,6,5,4,3,2,1,E,B,A,B,E,F,A,C; oe drops at TURN; done_o pulses once; err=00.
- Read, size=1, addr=0x0000_00A0, target returns ready then nibbles 5,C: data_o=0x0000_00C5, nsync rises the cycle after ready, err=00.
- Target drives 0011 (error and ready together) in WAIT: err_code_o=01, done_o pulses, data_o unchanged.
- No ready for TIMEOUT_CYCLES (use a 16-cycle build): err=10 on the 16th poll cycle, then back to IDLE.
- start_i held high throughout a transfer: exactly one transaction per accept; the second is accepted only after DONE.
- rst_ni pulsed during ADDR: nsync=1 and oe=0 asynchronously, busy_o=0, no done_o; the next request completes normally.
- ADDR_NIBBLES=4 with TURN_CYCLES=3: only 4 address nibbles are sent, and there are 3 released cycles before polling.

Source files
------------

// File: rtl/aud_rmm_ctrl.sv
// AUD remote-memory-access master: serialises sync, command, address and write
// data nibbles onto the 4-bit AUD bus, then polls the target and captures read data.
module aud_rmm_ctrl #(
    parameter int ADDR_NIBBLES   = 8,
    parameter int TURN_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    output logic [31:0] data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  err_code_o,
    input  logic [3:0]  aud_data_i,
    output logic [3:0]  aud_data_o,
    output logic        aud_data_oe_o,
    output logic        aud_nsync_o
);

    // One counter serves address, data, turnaround, poll and capture phases.
    localparam int CNT_W = (TO_W > 4) ? TO_W : 4;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_NIBBLES - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_STATUS  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SYNC,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_TURN,
        S_WAIT,
        S_RDATA,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        err_q, err_d;
    logic [CNT_W-1:0]  nib_last;
    logic [31:0]       cap;

    function automatic logic [3:0] nib_sel(input logic [31:0] word, input logic [2:0] k);
        nib_sel = 4'(word >> {k, 2'b00});
    endfunction

    function automatic logic [3:0] last_nib(input logic [1:0] size);
        last_nib = (4'd1 << size) - 4'd1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            rbuf_q  <= '0;
            data_q  <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            rbuf_q  <= rbuf_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        size_d        = size_q;
        cnt_d         = cnt_q;
        rbuf_d        = rbuf_q;
        data_d        = data_q;
        err_d         = err_q;
        aud_data_o    = 4'h0;
        aud_data_oe_o = 1'b0;
        aud_nsync_o   = 1'b1;
        done_o        = 1'b0;
        nib_last      = CNT_W'(last_nib(size_q));
        cap           = rbuf_q | (32'(aud_data_i) << {cnt_q[2:0], 2'b00});

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = data_i;
                    size_d  = size_i;
                    err_d   = ERR_OK;
                    cnt_d   = '0;
                    rbuf_d  = '0;
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                aud_data_oe_o = 1'b1;
                aud_nsync_o   = 1'b0;
                state_d       = S_CMD;
            end
            S_CMD: begin
                aud_data_oe_o = 1'b1;
                aud_nsync_o   = 1'b0;
                aud_data_o    = {1'b1, we_q, size_q};
                cnt_d         = '0;
                state_d       = S_ADDR;
            end
            S_ADDR: begin
                aud_data_oe_o = 1'b1;
                aud_nsync_o   = 1'b0;
                aud_data_o    = nib_sel(addr_q, cnt_q[2:0]);
                if (cnt_q == ADDR_LAST) begin
                    cnt_d   = '0;
                    state_d = we_q ? S_WDATA : S_TURN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WDATA: begin
                aud_data_oe_o = 1'b1;
                aud_nsync_o   = 1'b0;
                aud_data_o    = nib_sel(wdata_q, cnt_q[2:0]);
                if (cnt_q == nib_last) begin
                    cnt_d   = '0;
                    state_d = S_TURN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // Bus released; whatever the target drives here is not yet meaningful.
            S_TURN: begin
                aud_nsync_o = 1'b0;
                if (cnt_q == TURN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // A status error wins over a simultaneous ready indication.
            S_WAIT: begin
                aud_nsync_o = 1'b0;
                if (aud_data_i[3:1] != 3'b000) begin
                    err_d   = ERR_STATUS;
                    state_d = S_DONE;
                end else if (aud_data_i[0]) begin
                    cnt_d   = '0;
                    state_d = we_q ? S_DONE : S_RDATA;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RDATA: begin
                rbuf_d = cap;
                if (cnt_q == nib_last) begin
                    data_d  = cap;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o     = (state_q != S_IDLE);
    assign data_o     = data_q;
    assign err_code_o = err_q;

endmodule

// File: tb/tb_aud_rmm_ctrl.sv
// Bench for aud_rmm_ctrl: two builds (8 addr nibbles / 1 turn, 4 addr nibbles / 3 turn),
// a target model driving the poll/read responses, and a scoreboard monitor.
module tb_aud_rmm_ctrl;

    localparam int TMO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n  [2];
    logic        start  [2];
    logic        we     [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic [1:0]  size   [2];
    logic [31:0] data_o [2];
    logic        busy   [2];
    logic        done   [2];
    logic [1:0]  err    [2];
    logic [3:0]  aud_i  [2];
    logic [3:0]  aud_o  [2];
    logic        oe     [2];
    logic        nsync  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        aud_rmm_ctrl #(
            .ADDR_NIBBLES  (g == 0 ? 8 : 4),
            .TURN_CYCLES   (g == 0 ? 1 : 3),
            .TIMEOUT_CYCLES(TMO),
            .TO_W          (5)
        ) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n[g]),
            .start_i      (start[g]),
            .we_i         (we[g]),
            .addr_i       (addr[g]),
            .data_i       (wdata[g]),
            .size_i       (size[g]),
            .data_o       (data_o[g]),
            .busy_o       (busy[g]),
            .done_o       (done[g]),
            .err_code_o   (err[g]),
            .aud_data_i   (aud_i[g]),
            .aud_data_o   (aud_o[g]),
            .aud_data_oe_o(oe[g]),
            .aud_nsync_o  (nsync[g])
        );
    end

    typedef struct {
        int          g;
        logic [1:0]  err;
        logic [31:0] data;
        int          lat;
    } res_t;

    res_t        res_q[$];
    logic [4:0]  bus_q[$];
    logic [31:0] model_data [2];
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic int an_of(input int g);
        return (g == 0) ? 8 : 4;
    endfunction

    function automatic int tc_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: bus nibbles while driven, result record on every done pulse.
    initial begin
        int   acc_cyc [2];
        logic prev_busy [2];
        logic prev_done [2];
        logic [4:0] e;
        res_t r;
        for (int g = 0; g < 2; g++) begin
            acc_cyc[g] = 0; prev_busy[g] = 1'b0; prev_done[g] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (rst_n[g] !== 1'b1) begin
                    prev_busy[g] = 1'b0;
                    prev_done[g] = 1'b0;
                    continue;
                end
                if (busy[g] && !prev_busy[g]) acc_cyc[g] = cyc - 1;
                if (prev_done[g]) begin
                    chk("busy_after_done", 32'(busy[g]), 32'd0);
                    chk("done_width", 32'(done[g]), 32'd0);
                end
                if (oe[g]) begin
                    if (bus_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL bus_extra: inst %0d drove %0h with no nibble expected", g, aud_o[g]);
                    end else begin
                        e = bus_q.pop_front();
                        chk("bus_nibble", 32'({nsync[g], aud_o[g]}), 32'(e));
                    end
                end
                if (done[g]) begin
                    chk("bus_remaining", 32'(bus_q.size()), 32'd0);
                    if (res_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL done_unexpected: inst %0d pulsed done with nothing pending", g);
                    end else begin
                        r = res_q.pop_front();
                        chk("done_inst", 32'(g), 32'(r.g));
                        chk("err_code", 32'(err[g]), 32'(r.err));
                        chk("data_o", data_o[g], r.data);
                        chk("latency", 32'(cyc - acc_cyc[g]), 32'(r.lat));
                    end
                end
                prev_busy[g] = busy[g];
                prev_done[g] = done[g];
            end
        end
    end

    // One transaction: predict bus and result, then play the target side.
    task automatic txn(input int g, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input int polls, input logic [3:0] resp,
                       input bit tmo, input logic [31:0] rd, input bit hold);
        int          an;
        int          tc;
        int          nn;
        int          wc;
        bit          er;
        bit          ok;
        logic [31:0] mask;
        res_t        r;
        an = an_of(g);
        tc = tc_of(g);
        nn = 1 << s;
        er = !tmo && (resp[3:1] != 3'b000);
        ok = !tmo && !er && resp[0];
        wc = tmo ? TMO : polls;
        #1;
        bus_q.push_back(5'h00);
        bus_q.push_back({1'b0, 1'b1, w, s});
        for (int i = 0; i < an; i++) bus_q.push_back({1'b0, a[4*i +: 4]});
        if (w) for (int i = 0; i < nn; i++) bus_q.push_back({1'b0, d[4*i +: 4]});
        mask = (nn == 8) ? 32'hFFFF_FFFF : ((32'h1 << (4 * nn)) - 32'h1);
        if (!w && ok) model_data[g] = rd & mask;
        r.g    = g;
        r.err  = tmo ? 2'b10 : (er ? 2'b01 : 2'b00);
        r.data = model_data[g];
        r.lat  = 2 + an + (w ? nn : 0) + tc + wc + ((!w && ok) ? nn : 0) + 1;
        res_q.push_back(r);

        we[g] = w; addr[g] = a; wdata[g] = d; size[g] = s;
        start[g] = 1'b1;
        aud_i[g] = 4'($urandom);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (busy[g]) break;
        end
        chk("accepted", 32'(busy[g]), 32'd1);
        if (!hold) start[g] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!oe[g]) break;
        end
        for (int t = 0; t < tc; t++) begin
            if (t > 0) @(negedge clk);
            aud_i[g] = 4'($urandom);
        end
        for (int p = 1; p <= wc; p++) begin
            @(negedge clk);
            aud_i[g] = (p == wc && !tmo) ? resp : 4'h0;
        end
        if (!w && ok) begin
            for (int k = 0; k < nn; k++) begin
                @(negedge clk);
                if (k == 0) chk("nsync_after_ready", 32'(nsync[g]), 32'd1);
                aud_i[g] = rd[4*k +: 4];
            end
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            aud_i[g] = 4'($urandom);
            if (done[g]) break;
        end
        chk("done_seen", 32'(done[g]), 32'd1);
    endtask

    task automatic check_reset_vals(input int g);
        chk("rst_data_o", data_o[g], 32'd0);
        chk("rst_busy", 32'(busy[g]), 32'd0);
        chk("rst_done", 32'(done[g]), 32'd0);
        chk("rst_err", 32'(err[g]), 32'd0);
        chk("rst_aud_o", 32'(aud_o[g]), 32'd0);
        chk("rst_oe", 32'(oe[g]), 32'd0);
        chk("rst_nsync", 32'(nsync[g]), 32'd1);
    endtask

    // Reset pulse while address nibbles are on the bus.
    task automatic reset_mid(input int g);
        logic [31:0] a;
        a = 32'h89AB_CDEF;
        #1;
        bus_q.push_back(5'h00);
        bus_q.push_back({1'b0, 4'b1110});
        for (int i = 0; i < an_of(g); i++) bus_q.push_back({1'b0, a[4*i +: 4]});
        we[g] = 1'b1; addr[g] = a; wdata[g] = 32'h1357_9BDF; size[g] = 2'b10;
        start[g] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (busy[g]) break;
        end
        start[g] = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n[g] = 1'b0;
        #1;
        check_reset_vals(g);
        model_data[g] = 32'd0;
        bus_q.delete();
        @(negedge clk);
        rst_n[g] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_done_after_reset", 32'(done[g]), 32'd0);
        end
    endtask

    task automatic rand_txn(input int g);
        int          kind;
        logic [3:0]  resp;
        kind = $urandom_range(0, 9);
        if (kind < 7)      resp = 4'b0001;
        else               resp = {3'($urandom_range(1, 7)), 1'($urandom)};
        txn(g, 1'($urandom), $urandom, $urandom, 2'($urandom), $urandom_range(1, 6),
            resp, kind == 9, $urandom, ($urandom_range(0, 3) == 0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst_n[g] = 1'b0; start[g] = 1'b0; we[g] = 1'b0; addr[g] = '0;
            wdata[g] = '0; size[g] = '0; aud_i[g] = '0; model_data[g] = '0;
        end
        repeat (2) @(negedge clk);
        check_reset_vals(0);
        check_reset_vals(1);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        repeat (2) @(negedge clk);

        txn(0, 1'b1, 32'h1234_5678, 32'hCAFE_BABE, 2'd3, 3, 4'b0001, 1'b0, 32'h0, 1'b0);
        txn(0, 1'b0, 32'h0000_00A0, 32'h0, 2'd1, 1, 4'b0001, 1'b0, 32'hFFFF_FFC5, 1'b0);
        txn(0, 1'b0, 32'h0000_0040, 32'h0, 2'd2, 2, 4'b0011, 1'b0, 32'h0, 1'b0);
        txn(0, 1'b1, 32'h0000_0080, 32'h5555_AAAA, 2'd0, 0, 4'b0000, 1'b1, 32'h0, 1'b0);
        txn(0, 1'b0, 32'hDEAD_BEEF, 32'h0, 2'd3, 2, 4'b0001, 1'b0, 32'h8765_4321, 1'b1);
        txn(0, 1'b1, 32'h0BAD_F00D, 32'h7777_1111, 2'd2, 1, 4'b0001, 1'b0, 32'h0, 1'b1);
        txn(0, 1'b0, 32'h0000_0010, 32'h0, 2'd0, 4, 4'b0001, 1'b0, 32'h0000_0009, 1'b0);
        reset_mid(0);
        txn(0, 1'b0, 32'h4444_3333, 32'h0, 2'd2, 2, 4'b0001, 1'b0, 32'hABCD_1234, 1'b0);

        txn(1, 1'b1, 32'hFFFF_2468, 32'h0000_000D, 2'd0, 1, 4'b0001, 1'b0, 32'h0, 1'b0);
        txn(1, 1'b0, 32'h9999_ACE1, 32'h0, 2'd3, 3, 4'b0001, 1'b0, 32'h0F1E_2D3C, 1'b0);
        txn(1, 1'b1, 32'h0000_1111, 32'h2222_3333, 2'd1, 0, 4'b0000, 1'b1, 32'h0, 1'b0);

        for (int i = 0; i < 20; i++) rand_txn(0);
        start[0] = 1'b0;
        for (int i = 0; i < 20; i++) rand_txn(1);
        start[1] = 1'b0;

        repeat (5) @(negedge clk);
        chk("pending_results", 32'(res_q.size()), 32'd0);
        chk("final_busy0", 32'(busy[0]), 32'd0);
        chk("final_busy1", 32'(busy[1]), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
